// File: rtl/pe_pkg.sv
// Shared mode codes and feeder FSM encodings for the PE row feeder.
package pe_pkg;

  localparam logic [1:0] MODE_MAC  = 2'd0;
  localparam logic [1:0] MODE_OUT  = 2'd1;
  localparam logic [1:0] MODE_LOAD = 2'd2;  // reserved; the feeder never issues it
  localparam logic [1:0] MODE_IDLE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } feed_state_t;

endpackage

// File: rtl/pe_skew_line.sv
// Fixed-depth shift register used to delay one PE row's slot; DEPTH=0 degenerates to a wire.
module pe_skew_line
  import pe_pkg::*;
#(
  parameter int             DEPTH   = 1,
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_shift
      logic [W-1:0] stg [DEPTH];

      // Shift one stage per clock; reset clears every stage to the idle slot.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) stg[i] <= RST_VAL;
        end else begin
          stg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
        end
      end

      assign dout = stg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/pe_row_feeder.sv
// Feeder for a column of systolic PEs: frames K_LEN accepted beats as MAC slots followed by one
// OUT slot, registers the slot into row 0 and skews row r by r further cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no window open; first accepted beat opens one
// ST_RUN  | window open, fewer than K_LEN beats taken; gaps become bubbles
// ST_OUT  | one-cycle OUT slot, upstream stalled, then back to ST_IDLE
module pe_row_feeder
  import pe_pkg::*;
#(
  parameter int NUM_ROWS = 4,
  parameter int DATA_W   = 8,
  parameter int K_LEN    = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_ROWS*DATA_W-1:0] in_data,
  input  logic [NUM_ROWS*DATA_W-1:0] in_filter,
  output logic [NUM_ROWS*DATA_W-1:0] pe_in_o,
  output logic [NUM_ROWS*DATA_W-1:0] pe_filter_o,
  output logic [NUM_ROWS*2-1:0]      mode_o,
  output logic [NUM_ROWS-1:0]        activate_o,
  output logic                       busy,
  output logic                       win_done
);

  localparam int VEC_W  = NUM_ROWS * DATA_W;
  localparam int SLOT_W = 2 * DATA_W + 3;
  localparam int CNT_W  = $clog2(K_LEN + 1);
  localparam logic [SLOT_W-1:0] SLOT_IDLE = {{(2*DATA_W){1'b0}}, MODE_IDLE, 1'b0};

  feed_state_t        state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt, cnt_inc;
  logic               rdy_q;
  logic               accept;

  logic [VEC_W-1:0]   slot_data, slot_filt;
  logic [1:0]         slot_mode;
  logic               slot_act;

  logic [VEC_W-1:0]   data_q, filt_q;
  logic [1:0]         mode_q;
  logic               act_q;

  logic [SLOT_W-1:0]  row_slot [NUM_ROWS];
  logic [1:0]         last_pre_mode;
  logic               rows_active;
  logic               win_done_q;

  // in_ready is registered so it stays low through reset and the OUT cycle.
  assign in_ready = rdy_q;
  assign accept   = in_valid & rdy_q;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // FSM state, beat counter and ready flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      rdy_q   <= (state_nxt != ST_OUT);
    end
  end

  // Next state, count and the slot to launch into row 0 this cycle.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    slot_data = '0;
    slot_filt = '0;
    slot_mode = MODE_IDLE;
    slot_act  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          slot_data = in_data;
          slot_filt = in_filter;
          slot_mode = MODE_MAC;
          slot_act  = 1'b1;
          cnt_nxt   = CNT_W'(1);
          state_nxt = (K_LEN == 1) ? ST_OUT : ST_RUN;
        end
      end
      ST_RUN: begin
        slot_mode = MODE_MAC;
        if (accept) begin
          slot_data = in_data;
          slot_filt = in_filter;
          slot_act  = 1'b1;
          cnt_nxt   = cnt_inc;
          if (cnt_inc == CNT_W'(K_LEN)) state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        slot_mode = MODE_OUT;
        slot_act  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Row-0 stage holds the whole beat; each row's skew line then carries only its own lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      filt_q <= '0;
      mode_q <= MODE_IDLE;
      act_q  <= 1'b0;
    end else begin
      data_q <= slot_data;
      filt_q <= slot_filt;
      mode_q <= slot_mode;
      act_q  <= slot_act;
    end
  end

  generate
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      logic [SLOT_W-1:0] lane;
      assign lane = {data_q[r*DATA_W +: DATA_W], filt_q[r*DATA_W +: DATA_W], mode_q, act_q};

      if (r == 0) begin : g_direct
        assign row_slot[r] = lane;
      end else begin : g_skew
        pe_skew_line #(
          .DEPTH   (r),
          .W       (SLOT_W),
          .RST_VAL (SLOT_IDLE)
        ) u_skew (
          .clk  (clk),
          .rst  (rst),
          .din  (lane),
          .dout (row_slot[r])
        );
      end

      assign pe_in_o[r*DATA_W +: DATA_W]     = row_slot[r][SLOT_W-1 -: DATA_W];
      assign pe_filter_o[r*DATA_W +: DATA_W] = row_slot[r][SLOT_W-1-DATA_W -: DATA_W];
      assign mode_o[2*r +: 2]                = row_slot[r][2:1];
      assign activate_o[r]                   = row_slot[r][0];
    end

    // The value row NUM_ROWS-1 will show next cycle is what row NUM_ROWS-2 shows now.
    if (NUM_ROWS == 1) begin : g_pre_slot
      assign last_pre_mode = slot_mode;
    end else begin : g_pre_row
      assign last_pre_mode = row_slot[NUM_ROWS-2][2:1];
    end
  endgenerate

  // Row outputs cover every distinct skew stage (delays 1..NUM_ROWS), so they suffice for busy.
  always_comb begin
    rows_active = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      rows_active = rows_active | row_slot[r][0] | (row_slot[r][2:1] != MODE_IDLE);
    end
  end

  assign busy = (state_q != ST_IDLE) | rows_active;

  // Window-done pulse, aligned with the last row's OUT slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) win_done_q <= 1'b0;
    else      win_done_q <= (last_pre_mode == MODE_OUT);
  end

  assign win_done = win_done_q;

endmodule

// File: tb/tb_pe_row_feeder.sv
// Directed bench for pe_row_feeder (NUM_ROWS=4, DATA_W=8, K_LEN=3).
module tb_pe_row_feeder;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int KL = 3;

  // Hand-written row-0 slot codes: value >= 0 is a MAC beat with that value.
  localparam int C_IDLE = -1;
  localparam int C_OUT  = -2;
  localparam int C_BUB  = -3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [NR*DW-1:0] in_data;
  logic [NR*DW-1:0] in_filter;
  logic [NR*DW-1:0] pe_in_o;
  logic [NR*DW-1:0] pe_filter_o;
  logic [NR*2-1:0]  mode_o;
  logic [NR-1:0]    activate_o;
  logic            busy;
  logic            win_done;

  pe_row_feeder #(.NUM_ROWS(NR), .DATA_W(DW), .K_LEN(KL)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_filter   (in_filter),
    .pe_in_o     (pe_in_o),
    .pe_filter_o (pe_filter_o),
    .mode_o      (mode_o),
    .activate_o  (activate_o),
    .busy        (busy),
    .win_done    (win_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int rs     = 0;   // per-row data step

  int code_q[$];
  bit vld_q[$];
  bit rdy_q[$];
  int beat_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] exp_slot(input int code, input int r);
    logic [7:0] d, f;
    case (code)
      C_IDLE:  return {8'd0, 8'd0, 2'd3, 1'b0};
      C_OUT:   return {8'd0, 8'd0, 2'd1, 1'b1};
      C_BUB:   return {8'd0, 8'd0, 2'd0, 1'b0};
      default: begin
        d = 8'(code + rs * r);
        f = 8'(code + 1 + rs * r);
        return {d, f, 2'd0, 1'b1};
      end
    endcase
  endfunction

  function automatic logic [18:0] obs_slot(input int r);
    return {pe_in_o[r*DW +: DW], pe_filter_o[r*DW +: DW], mode_o[2*r +: 2], activate_o[r]};
  endfunction

  task automatic set_beat(input int v);
    for (int r = 0; r < NR; r++) begin
      in_data[r*DW +: DW]   = 8'(v + rs * r);
      in_filter[r*DW +: DW] = 8'(v + 1 + rs * r);
    end
  endtask

  task automatic chk_all_idle(input string tag);
    for (int r = 0; r < NR; r++) chk($sformatf("%s row%0d", tag, r), obs_slot(r), exp_slot(C_IDLE, r));
    chk({tag, " in_ready"}, in_ready, 1'b0);
    chk({tag, " busy"}, busy, 1'b0);
    chk({tag, " win_done"}, win_done, 1'b0);
  endtask

  // Walk the hand-written sequence; row r at cycle c must show row-0 code c-1-r.
  task automatic run_seq(input string name);
    int  len;
    int  k, code, prev;
    bit  exp_busy, acc;
    len = code_q.size();
    for (int c = 0; c < len + NR + 2; c++) begin
      exp_busy = 1'b0;
      for (int r = 0; r < NR; r++) begin
        k    = c - 1 - r;
        code = (k >= 0 && k < len) ? code_q[k] : C_IDLE;
        if (code != C_IDLE) exp_busy = 1'b1;
        chk($sformatf("%s c%0d row%0d", name, c, r), obs_slot(r), exp_slot(code, r));
      end
      k = c - NR;
      chk($sformatf("%s c%0d win_done", name, c), win_done,
          (k >= 0 && k < len && code_q[k] == C_OUT));
      prev = (c >= 1 && c - 1 < len) ? code_q[c-1] : C_IDLE;
      if (prev >= 0 || prev == C_BUB) exp_busy = 1'b1;
      chk($sformatf("%s c%0d busy", name, c), busy, exp_busy);
      chk($sformatf("%s c%0d in_ready", name, c), in_ready, (c < len) ? rdy_q[c] : 1'b1);

      in_valid = (c < len) ? vld_q[c] : 1'b0;
      if (beat_q.size() > 0) set_beat(beat_q[0]);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      if (acc && beat_q.size() > 0) void'(beat_q.pop_front());
    end
    in_valid = 1'b0;
    chk({name, " beats_left"}, beat_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with in_valid high, then release
    rst       = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    in_filter = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    chk_all_idle("reset");
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("release in_ready same cycle", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("release in_ready next cycle", in_ready, 1'b1);
    chk("release modes", mode_o, 8'hFF);
    chk("release act", activate_o, 4'h0);

    // 2: one window, identical data on all rows
    rs = 0;
    code_q = '{1, 2, 3, C_OUT};
    vld_q  = '{1, 1, 1, 0};
    rdy_q  = '{1, 1, 1, 0};
    beat_q = '{1, 2, 3};
    run_seq("win");

    // 3: two-cycle bubble after the first beat
    code_q = '{1, C_BUB, C_BUB, 2, 3, C_OUT};
    vld_q  = '{1, 0, 0, 1, 1, 0};
    rdy_q  = '{1, 1, 1, 1, 1, 0};
    beat_q = '{1, 2, 3};
    run_seq("bubble");

    // 4: back-to-back windows, beat 4 held through the OUT cycle
    code_q = '{1, 2, 3, C_OUT, 4, 5, 6, C_OUT};
    vld_q  = '{1, 1, 1, 1, 1, 1, 1, 0};
    rdy_q  = '{1, 1, 1, 0, 1, 1, 1, 0};
    beat_q = '{1, 2, 3, 4, 5, 6};
    run_seq("b2b");

    // 5: asynchronous reset after two beats
    in_valid = 1'b1;
    set_beat(1);
    @(posedge clk); #1;
    set_beat(2);
    @(posedge clk); #1;
    chk("arst pre row1", obs_slot(1), exp_slot(1, 1));
    set_beat(3);
    #3;
    rst = 1'b0;
    #1;
    chk_all_idle("arst now");
    repeat (3) begin
      @(posedge clk); #1;
      chk("arst hold win_done", win_done, 1'b0);
      chk("arst hold modes", mode_o, 8'hFF);
    end
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("arst release ready", in_ready, 1'b1);
    code_q = '{7, 8, 9, C_OUT};
    vld_q  = '{1, 1, 1, 0};
    rdy_q  = '{1, 1, 1, 0};
    beat_q = '{7, 8, 9};
    run_seq("post_arst");

    // 6: distinct per-row data to expose the skew
    rs = 16;
    code_q = '{1, 2, 3, C_OUT};
    vld_q  = '{1, 1, 1, 0};
    rdy_q  = '{1, 1, 1, 0};
    beat_q = '{1, 2, 3};
    run_seq("skew");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
